arc4_stream_engine: RTL and testbench

// Parametrised ARC4 decrypt engine; successor to the fixed 24-bit arc4 core used by the key cracker.

---
 rtl/arc4_stream_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_arc4_stream_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_stream_engine.sv
// ARC4 decrypt engine: length-prefixed ciphertext in, length-prefixed plaintext out.
// The S array sits in an external single-port memory with S_RD_LAT cycles of read latency.
//
// state  | meaning
// IDLE   | waiting for start, rdy=1
// INIT   | S[n]=n for n=0..255
// KR_I   | KSA: present i, wait for S[i]
// KR_J   | KSA: take si, advance j, present j, wait for S[j]
// KW_I   | KSA: S[i]=sj
// KW_J   | KSA: S[j]=si, advance i and key index
// P_LEN  | take length byte L
// P_LOUT | emit L
// P_IN   | take ciphertext byte, i=i+1
// P_RI   | PRGA: present i, wait
// P_RJ   | PRGA: take si, advance j, present j, wait
// P_WI   | PRGA: S[i]=sj
// P_WJ   | PRGA: S[j]=si
// P_RP   | PRGA: present si+sj, wait
// P_KS   | latch plaintext byte, update printable flag
// P_OUT  | emit plaintext byte
// DRAIN  | discard remaining ciphertext after an early abort
// DONE   | res_valid pulse
module arc4_stream_engine #(
   parameter int         KEY_BYTES   = 3,
   parameter int         S_RD_LAT    = 1,
   parameter logic [7:0] PRINT_LO    = 8'h20,
   parameter logic [7:0] PRINT_HI    = 8'h7E,
   parameter bit         EARLY_ABORT = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   rdy,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             s_addr,
   output logic [7:0]             s_wrdata,
   output logic                   s_wren,
   input  logic [7:0]             s_rddata,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_data,
   output logic                   res_valid,
   output logic                   printable
);

   localparam int              KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [1:0]      LAST_W = 2'(S_RD_LAT - 1);
   localparam logic [KW-1:0]   LAST_K = KW'(KEY_BYTES - 1);

   typedef enum logic [4:0] {
      IDLE, INIT, KR_I, KR_J, KW_I, KW_J,
      P_LEN, P_LOUT, P_IN, P_RI, P_RJ, P_WI, P_WJ, P_RP, P_KS, P_OUT,
      DRAIN, DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [8*KEY_BYTES-1:0] key_r;
   logic [7:0]             i_r, j_r, si_r, sj_r, ct_r, rem_r, dout_r;
   logic [KW-1:0]          kidx_r;
   logic [1:0]             wcnt_r;
   logic                   prt_r;

   logic [7:0] key_byte, j_nxt, pt;
   logic       is_wait, wait_done, first_cyc, byte_ok;
   logic [7:0] addr_c, wdata_c;
   logic       wren_c, in_rdy_c, out_vld_c, res_c;

   always_comb begin
      key_byte = 8'h00;
      for (int b = 0; b < KEY_BYTES; b++)
         if (kidx_r == KW'(b)) key_byte = key_r[8*(KEY_BYTES-1-b) +: 8];
   end

   // KSA adds the key byte to j; PRGA does not
   assign j_nxt     = j_r + s_rddata + ((state == KR_J) ? key_byte : 8'h00);
   assign pt        = ct_r ^ s_rddata;
   assign byte_ok   = (pt >= PRINT_LO) && (pt <= PRINT_HI);
   assign is_wait   = (state == KR_I) || (state == KR_J) || (state == P_RI) ||
                      (state == P_RJ) || (state == P_RP);
   assign wait_done = (wcnt_r == LAST_W);
   assign first_cyc = (wcnt_r == 2'd0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr_c    = 8'h00;
      wdata_c   = 8'h00;
      wren_c    = 1'b0;
      in_rdy_c  = 1'b0;
      out_vld_c = 1'b0;
      res_c     = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = INIT;
         INIT: begin
            wren_c  = 1'b1;
            addr_c  = i_r;
            wdata_c = i_r;
            if (i_r == 8'hFF) state_nxt = KR_I;
         end
         KR_I, P_RI: begin
            addr_c = i_r;
            if (wait_done) state_nxt = (state == KR_I) ? KR_J : P_RJ;
         end
         KR_J, P_RJ: begin
            addr_c = first_cyc ? j_nxt : j_r;
            if (wait_done) state_nxt = (state == KR_J) ? KW_I : P_WI;
         end
         KW_I, P_WI: begin
            wren_c    = 1'b1;
            addr_c    = i_r;
            wdata_c   = s_rddata;
            state_nxt = (state == KW_I) ? KW_J : P_WJ;
         end
         KW_J: begin
            wren_c  = 1'b1;
            addr_c  = j_r;
            wdata_c = si_r;
            state_nxt = (i_r == 8'hFF) ? P_LEN : KR_I;
         end
         P_LEN: begin
            in_rdy_c = 1'b1;
            if (in_valid) state_nxt = P_LOUT;
         end
         P_LOUT: begin
            out_vld_c = 1'b1;
            if (out_ready) state_nxt = (rem_r == 8'd0) ? DONE : P_IN;
         end
         P_IN: begin
            in_rdy_c = 1'b1;
            if (in_valid) state_nxt = P_RI;
         end
         P_WJ: begin
            wren_c    = 1'b1;
            addr_c    = j_r;
            wdata_c   = si_r;
            state_nxt = P_RP;
         end
         P_RP: begin
            addr_c = si_r + sj_r;
            if (wait_done) state_nxt = P_KS;
         end
         P_KS:   state_nxt = P_OUT;
         P_OUT: begin
            out_vld_c = 1'b1;
            if (out_ready) begin
               if (rem_r == 8'd1)              state_nxt = DONE;
               else if (EARLY_ABORT && !prt_r) state_nxt = DRAIN;
               else                            state_nxt = P_IN;
            end
         end
         DRAIN: begin
            in_rdy_c = 1'b1;
            if (in_valid && rem_r == 8'd1) state_nxt = DONE;
         end
         DONE: begin
            res_c     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Gate on rst so that no write or handshake escapes during the reset cycle itself
   assign rdy       = rst | (state == IDLE);
   assign s_addr    = rst ? 8'h00 : addr_c;
   assign s_wrdata  = rst ? 8'h00 : wdata_c;
   assign s_wren    = wren_c & ~rst;
   assign in_ready  = in_rdy_c & ~rst;
   assign out_valid = out_vld_c & ~rst;
   assign res_valid = res_c & ~rst;
   assign printable = res_valid & prt_r;
   assign out_data  = dout_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_r  <= '0;
         i_r    <= 8'h00;
         j_r    <= 8'h00;
         si_r   <= 8'h00;
         sj_r   <= 8'h00;
         ct_r   <= 8'h00;
         rem_r  <= 8'h00;
         dout_r <= 8'h00;
         kidx_r <= '0;
         wcnt_r <= 2'd0;
         prt_r  <= 1'b0;
      end else begin
         wcnt_r <= (is_wait && !wait_done) ? wcnt_r + 2'd1 : 2'd0;
         case (state)
            IDLE: if (start) begin
               key_r  <= key;
               i_r    <= 8'h00;
               j_r    <= 8'h00;
               kidx_r <= '0;
               prt_r  <= 1'b1;
            end
            INIT: i_r <= i_r + 8'd1;
            KR_J, P_RJ: if (first_cyc) begin
               si_r <= s_rddata;
               j_r  <= j_nxt;
            end
            KW_I, P_WI: sj_r <= s_rddata;
            KW_J: begin
               // i wraps to 0 on the last KSA step; j is cleared for the PRGA
               i_r    <= i_r + 8'd1;
               kidx_r <= (kidx_r == LAST_K) ? '0 : kidx_r + 1'b1;
               if (i_r == 8'hFF) j_r <= 8'h00;
            end
            P_LEN: if (in_valid) begin
               rem_r  <= in_data;
               dout_r <= in_data;
            end
            P_IN: if (in_valid) begin
               ct_r <= in_data;
               i_r  <= i_r + 8'd1;
            end
            P_KS: begin
               dout_r <= pt;
               if (!byte_ok) prt_r <= 1'b0;
            end
            P_OUT: if (out_ready) rem_r <= rem_r - 8'd1;
            DRAIN: if (in_valid)  rem_r <= rem_r - 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_stream_engine.sv
// Bench for arc4_stream_engine: four parameter sets, each with its own S memory model,
// checked against a plain-arithmetic RC4 reference and known vectors.
module tb_arc4_stream_engine;

   localparam int ND      = 4;
   localparam int TIMEOUT = 6000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start_s     [ND];
   logic         rdy_s       [ND];
   logic [127:0] key_s       [ND];
   logic [7:0]   s_addr_s    [ND];
   logic [7:0]   s_wrdata_s  [ND];
   logic         s_wren_s    [ND];
   logic [7:0]   s_rddata_s  [ND];
   logic         in_valid_s  [ND];
   logic         in_ready_s  [ND];
   logic [7:0]   in_data_s   [ND];
   logic         out_valid_s [ND];
   logic         out_ready_s [ND];
   logic [7:0]   out_data_s  [ND];
   logic         res_valid_s [ND];
   logic         printable_s [ND];

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] ct_q  [$];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   bit         exp_prt;

   // d0: 3-byte key, lat 1 | d1: 3-byte key, lat 2, early abort | d2: 4-byte, lat 1 | d3: 4-byte, lat 2
   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int KB  = (g >= 2) ? 4 : 3;
      localparam int LAT = (g == 1 || g == 3) ? 2 : 1;
      localparam bit EA  = (g == 1);
      logic [7:0] mem [256];
      logic [7:0] p1, p2;

      arc4_stream_engine #(
         .KEY_BYTES(KB), .S_RD_LAT(LAT), .PRINT_LO(8'h20), .PRINT_HI(8'h7E), .EARLY_ABORT(EA)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start_s[g]), .rdy(rdy_s[g]), .key(key_s[g][8*KB-1:0]),
         .s_addr(s_addr_s[g]), .s_wrdata(s_wrdata_s[g]), .s_wren(s_wren_s[g]), .s_rddata(s_rddata_s[g]),
         .in_valid(in_valid_s[g]), .in_ready(in_ready_s[g]), .in_data(in_data_s[g]),
         .out_valid(out_valid_s[g]), .out_ready(out_ready_s[g]), .out_data(out_data_s[g]),
         .res_valid(res_valid_s[g]), .printable(printable_s[g])
      );

      always_ff @(posedge clk) begin
         if (s_wren_s[g]) mem[s_addr_s[g]] <= s_wrdata_s[g];
         p1 <= mem[s_addr_s[g]];
         p2 <= p1;
      end
      assign s_rddata_s[g] = (LAT == 2) ? p2 : p1;
   end

   function automatic int kb_of(input int d);
      return (d >= 2) ? 4 : 3;
   endfunction

   function automatic bit ea_of(input int d);
      return (d == 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Textbook RC4 over an int array; fills exp_q / exp_prt from ct_q
   function automatic void model(input logic [127:0] k, input int kb, input bit ea);
      int s [256];
      int i, j, t;
      logic [7:0] pt;
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int a = 0; a < 256; a++) begin
         j = (j + s[a] + int'(k[8*(kb-1-(a % kb)) +: 8])) % 256;
         t = s[a]; s[a] = s[j]; s[j] = t;
      end
      exp_q.delete();
      exp_q.push_back(ct_q[0]);
      exp_prt = 1'b1;
      i = 0;
      j = 0;
      for (int n = 1; n < ct_q.size(); n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         pt = ct_q[n] ^ 8'(s[(s[i] + s[j]) % 256]);
         exp_q.push_back(pt);
         if (pt < 8'h20 || pt > 8'h7E) begin
            exp_prt = 1'b0;
            if (ea) break;
         end
      end
   endfunction

   task automatic reset_and_check(input int d);
      for (int x = 0; x < ND; x++) begin
         in_valid_s[x]  = 1'b0;
         out_ready_s[x] = 1'b0;
         start_s[x]     = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("rst_cycle_wren", 32'(s_wren_s[d]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_rdy", 32'(rdy_s[d]), 32'd1);
      check("rst_out_valid", 32'(out_valid_s[d]), 32'd0);
      check("rst_in_ready", 32'(in_ready_s[d]), 32'd0);
      check("rst_wren", 32'(s_wren_s[d]), 32'd0);
      check("rst_addr", 32'(s_addr_s[d]), 32'd0);
      check("rst_out_data", 32'(out_data_s[d]), 32'd0);
      check("rst_res_valid", 32'(res_valid_s[d]), 32'd0);
      check("rst_printable", 32'(printable_s[d]), 32'd0);
   endtask

   // rst_at >= 0: stop accepting output after rst_at bytes, then reset after a 3-cycle stall
   task automatic run_msg(input int d, input logic [127:0] k, input bit rnd, input bit chk_init,
                          input int rst_at);
      int         src, cyc, stall_n;
      bit         done, prev_stall, got_prt;
      logic [7:0] prev_data;
      got_q.delete();
      src = 0; cyc = 0; stall_n = 0;
      done = 1'b0; prev_stall = 1'b0; got_prt = 1'b0; prev_data = 8'h00;
      @(negedge clk);
      start_s[d] = 1'b1;
      key_s[d]   = k;
      @(negedge clk);
      start_s[d] = 1'b0;
      check("rdy_drop", 32'(rdy_s[d]), 32'd0);
      if (chk_init) begin
         for (int n = 0; n < 256; n++) begin
            check("init_wren", 32'(s_wren_s[d]), 32'd1);
            check("init_addr", 32'(s_addr_s[d]), 32'(n));
            check("init_data", 32'(s_wrdata_s[d]), 32'(n));
            @(negedge clk);
         end
         check("init_end_wren", 32'(s_wren_s[d]), 32'd0);
      end
      while (!done && cyc < TIMEOUT) begin
         in_valid_s[d]  = (src < ct_q.size()) && (!rnd || $urandom_range(0, 2) != 0);
         in_data_s[d]   = (src < ct_q.size()) ? ct_q[src] : 8'h00;
         out_ready_s[d] = (rst_at >= 0 && got_q.size() >= rst_at) ? 1'b0 :
                          (!rnd || $urandom_range(0, 1) == 1);
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid_s[d]), 32'd1);
            check("stall_data", 32'(out_data_s[d]), 32'(prev_data));
         end
         check("in_out_exclusive", 32'(in_ready_s[d] & out_valid_s[d]), 32'd0);
         if (in_valid_s[d] && in_ready_s[d]) src++;
         if (out_valid_s[d] && out_ready_s[d]) got_q.push_back(out_data_s[d]);
         if (res_valid_s[d]) begin
            done    = 1'b1;
            got_prt = printable_s[d];
         end
         prev_stall = out_valid_s[d] && !out_ready_s[d];
         prev_data  = out_data_s[d];
         if (rst_at >= 0 && prev_stall) stall_n++;
         if (stall_n == 3) begin
            reset_and_check(d);
            return;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid_s[d]  = 1'b0;
      out_ready_s[d] = 1'b0;
      check("res_timeout", 32'(done), 32'd1);
      check("in_consumed", 32'(src), 32'(ct_q.size()));
      check("out_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int n = 0; n < got_q.size() && n < exp_q.size(); n++)
         check($sformatf("out_byte%0d", n), 32'(got_q[n]), 32'(exp_q[n]));
      check("printable", 32'(got_prt), 32'(exp_prt));
      check("rdy_back", 32'(rdy_s[d]), 32'd1);
   endtask

   task automatic load_t1();
      ct_q  = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      exp_q = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      exp_prt = 1'b1;
   endtask

   task automatic load_t2();
      ct_q  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
      exp_q = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      exp_prt = 1'b1;
   endtask

   initial begin
      logic [127:0] k;
      int           len;
      for (int x = 0; x < ND; x++) begin
         start_s[x] = 1'b0; key_s[x] = '0; in_valid_s[x] = 1'b0;
         in_data_s[x] = 8'h00; out_ready_s[x] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < ND; d++) begin
         check("por_rdy", 32'(rdy_s[d]), 32'd1);
         check("por_wren", 32'(s_wren_s[d]), 32'd0);
         check("por_out_valid", 32'(out_valid_s[d]), 32'd0);
         check("por_out_data", 32'(out_data_s[d]), 32'd0);
         check("por_printable", 32'(printable_s[d]), 32'd0);
      end

      load_t1(); run_msg(0, 128'h4B6579, 1'b0, 1'b0, -1);
      load_t1(); run_msg(1, 128'h4B6579, 1'b0, 1'b0, -1);
      load_t2(); run_msg(2, 128'h57696B69, 1'b0, 1'b0, -1);
      load_t2(); run_msg(3, 128'h57696B69, 1'b0, 1'b0, -1);
      load_t1(); run_msg(0, 128'h4B6579, 1'b1, 1'b0, -1);
      load_t2(); run_msg(3, 128'h57696B69, 1'b1, 1'b0, -1);

      ct_q = '{8'h03, 8'h00, 8'h00, 8'h00};
      model(128'h4B6579, 3, 1'b1);
      check("abort_model_len", 32'(exp_q.size()), 32'd2);
      run_msg(1, 128'h4B6579, 1'b1, 1'b0, -1);

      ct_q = '{8'h00};
      exp_q = '{8'h00};
      exp_prt = 1'b1;
      run_msg(0, 128'h4B6579, 1'b0, 1'b1, -1);

      @(negedge clk);
      start_s[0] = 1'b1;
      key_s[0]   = 128'h4B6579;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (300) @(negedge clk);
      reset_and_check(0);
      load_t1(); run_msg(0, 128'h4B6579, 1'b0, 1'b0, 2);
      load_t1(); run_msg(0, 128'h4B6579, 1'b1, 1'b0, -1);

      for (int d = 0; d < ND; d++) begin
         for (int r = 0; r < 3; r++) begin
            len = $urandom_range(0, 16);
            ct_q.delete();
            ct_q.push_back(8'(len));
            repeat (len) ct_q.push_back(8'($urandom));
            k = {$urandom, $urandom, $urandom, $urandom};
            model(k, kb_of(d), ea_of(d));
            run_msg(d, k, 1'b1, 1'b0, -1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
